// File: rtl/program_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Word sizes and loader FSM encoding.
package program_loader_pkg;

  localparam int HALF_WORD = 16;
  localparam int WORD      = 32;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE    = 3'd0;
  localparam loader_state_t ST_LEN_LO  = 3'd1;
  localparam loader_state_t ST_LEN_HI  = 3'd2;
  localparam loader_state_t ST_DATA_LO = 3'd3;
  localparam loader_state_t ST_DATA_HI = 3'd4;
  localparam loader_state_t ST_WRITE   = 3'd5;
  localparam loader_state_t ST_DONE    = 3'd6;
  localparam loader_state_t ST_ERROR   = 3'd7;

  function automatic logic byte_wait(input loader_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
           (s == ST_DATA_LO) || (s == ST_DATA_HI);
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle watchdog between accepted host bytes.
// expired is high once the count reaches TIMEOUT_CYCLES-1.
module loader_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (count_i && !expired_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/program_loader.sv
// Host byte-stream loader for the arm_cpu instruction memory.
// Holds the core in reset until a length-prefixed image is written.
import program_loader_pkg::*;

module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_HALFWORDS  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  loader_state_t        state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          idx_q, idx_d;
  logic [7:0]           lo_q, lo_d;
  logic [HALF_WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0]      addr_q, addr_d;

  logic        accept;
  logic        expired;
  logic        to_clear;
  logic [15:0] len_w;

  assign byte_ready_o = byte_wait(state_q);
  assign accept       = byte_valid_i && byte_ready_o;
  assign len_w        = {byte_i, len_q[7:0]};

  assign program_mem_write_en_o = (state_q == ST_WRITE);
  assign instruction_o          = instr_q;
  assign instruction_addr_o     = addr_q;
  assign busy_o  = byte_ready_o || (state_q == ST_WRITE);
  assign done_o  = (state_q == ST_DONE);
  assign error_o = (state_q == ST_ERROR);
  assign cpu_reset_o = (state_q != ST_DONE);

  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (to_clear || accept),
    .count_i  (byte_ready_o && !accept),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    to_clear = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d  = ST_LEN_LO;
          to_clear = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_i;
          state_d    = ST_LEN_HI;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_w;
          if (len_w == 16'd0)
            state_d = ST_DONE;
          else if (32'(len_w) > MAX_HALFWORDS)
            state_d = ST_ERROR;
          else begin
            state_d = ST_DATA_LO;
            idx_d   = 16'd0;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_d    = byte_i;
          state_d = ST_DATA_HI;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          instr_d = {byte_i, lo_q};
          // 32-bit sum wraps past the top of the address space
          addr_d  = BASE_ADDR + {15'd0, idx_q, 1'b0};
          state_d = ST_WRITE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (idx_d == len_q) ? ST_DONE : ST_DATA_LO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      instr_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Two instances share stimulus; the second sits at the top of memory.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  byt = 8'h00;

  logic        ready, we, cpu_rst, busy, done, err;
  logic [15:0] instr;
  logic [31:0] addr;

  logic        ready2, we2, cpu_rst2, busy2, done2, err2;
  logic [15:0] instr2;
  logic [31:0] addr2;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  logic [47:0] q1[$];
  logic [47:0] q2[$];

  always #5 clk = ~clk;

  program_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_HALFWORDS(1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .byte_valid_i(valid), .byte_i(byt), .byte_ready_o(ready),
    .program_mem_write_en_o(we), .instruction_o(instr),
    .instruction_addr_o(addr), .cpu_reset_o(cpu_rst),
    .busy_o(busy), .done_o(done), .error_o(err)
  );

  program_loader #(
    .BASE_ADDR(32'hFFFF_FFFE),
    .MAX_HALFWORDS(1024),
    .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .byte_valid_i(valid), .byte_i(byt), .byte_ready_o(ready2),
    .program_mem_write_en_o(we2), .instruction_o(instr2),
    .instruction_addr_o(addr2), .cpu_reset_o(cpu_rst2),
    .busy_o(busy2), .done_o(done2), .error_o(err2)
  );

  always @(negedge clk) begin
    if (we)  q1.push_back({addr, instr});
    if (we2) q2.push_back({addr2, instr2});
    if (ready && (we || done || err || !busy)) viol++;
  end

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    valid = 1'b0;
    repeat (gap) tick();
    valid = 1'b1;
    byt   = b;
    n     = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 48'd0, 48'd1);
    else tick();
    valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_cpu_reset", 48'(cpu_rst), 48'd1);
    chk("rst_flags", {45'd0, busy, done, err}, 48'd0);
    chk("rst_ready_we", {46'd0, ready, we}, 48'd0);
    chk("rst_data", {addr, instr}, 48'd0);
    reset = 1'b0;
    tick();

    // basic load, valid held high
    pulse_start();
    chk("start_busy", {46'd0, busy, cpu_rst}, 48'd3);
    send(8'h02, 0); send(8'h00, 0);
    send(8'h34, 0); send(8'h12, 0);
    send(8'h78, 0); send(8'h56, 0);
    chk("basic_write2", {15'd0, we, addr, instr}, {15'd0, 1'b1, 32'h2, 16'h5678});
    tick();
    chk("basic_done", {45'd0, done, cpu_rst, busy}, 48'b100);
    chk("basic_nw", 48'(q1.size()), 48'd2);
    chk("basic_w0", q1[0], {32'h0, 16'h1234});
    chk("basic_w1", q1[1], {32'h2, 16'h5678});
    chk("wrap_nw", 48'(q2.size()), 48'd2);
    chk("wrap_w0", q2[0], {32'hFFFF_FFFE, 16'h1234});
    chk("wrap_w1", q2[1], {32'h0, 16'h5678});

    // restart from DONE, then gappy stream
    pulse_start();
    chk("restart", {45'd0, cpu_rst, done, busy}, 48'b101);
    q1.delete(); q2.delete();
    send(8'h02, 3); send(8'h00, 0);
    send(8'h34, 5); send(8'h12, 1);
    send(8'h78, 2); send(8'h56, 4);
    tick();
    chk("gappy_done", 48'(done), 48'd1);
    chk("gappy_nw", 48'(q1.size()), 48'd2);
    chk("gappy_w0", q1[0], {32'h0, 16'h1234});
    chk("gappy_w1", q1[1], {32'h2, 16'h5678});
    chk("ready_viol", 48'(viol), 48'd0);

    // zero length
    q1.delete();
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    chk("zero_done", {45'd0, done, err, cpu_rst}, 48'b100);
    chk("zero_nw", 48'(q1.size()), 48'd0);

    // oversize length 0x0401
    pulse_start();
    send(8'h01, 0); send(8'h04, 0);
    chk("over_err", {44'd0, err, cpu_rst, done, ready}, 48'b1100);
    chk("over_nw", 48'(q1.size()), 48'd0);

    // timeout after stall in DATA_HI
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h34, 0);
    repeat (15) tick();
    chk("to_not_yet", {46'd0, err, busy}, 48'b01);
    tick();
    chk("to_err", {46'd0, err, cpu_rst}, 48'b11);
    chk("to_nw", 48'(q1.size()), 48'd0);

    // accept on the last permitted cycle
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h34, 0);
    send(8'h12, 15);
    chk("to_edge_write", {15'd0, we, addr, instr}, {15'd0, 1'b1, 32'h0, 16'h1234});
    tick();
    chk("to_edge_done", {46'd0, done, err}, 48'b10);
    chk("to_edge_nw", 48'(q1.size()), 48'd1);

    // start ignored while busy
    q1.delete();
    pulse_start();
    send(8'h01, 0); send(8'h00, 0);
    pulse_start();
    chk("busy_start", {46'd0, busy, ready}, 48'b11);
    send(8'hCD, 0); send(8'hAB, 0);
    tick();
    chk("busy_done", 48'(done), 48'd1);
    chk("busy_nw", 48'(q1.size()), 48'd1);
    chk("busy_w0", q1[0], {32'h0, 16'hABCD});

    // reset in DATA_HI
    q1.delete();
    pulse_start();
    send(8'h01, 0); send(8'h00, 0); send(8'h34, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_flags", {42'd0, cpu_rst, busy, done, err, ready, we}, 48'b100000);
    chk("mid_rst_data", {addr, instr}, 48'd0);
    valid = 1'b1; byt = 8'h12;
    repeat (4) tick();
    valid = 1'b0;
    chk("mid_rst_idle", {46'd0, busy, ready}, 48'd0);
    chk("mid_rst_nw", 48'(q1.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
